dfx_debug_reg_responder: RTL
============================

DFX_DEBUG_REG_RESPONDER -- requirements
Module: dfx_debug_reg_responder

Interface
REQ-001 Parameter ID_VALUE, default 32'hDF0C_0001, constant returned by the ID register.
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000, 256-byte-aligned base of the register window.
REQ-003 Clock McuAxiClock, single clock for all logic; reset mMcuAxiReset_n is synchronous and active-low.
REQ-004 Ports, listed as name  direction  width  meaning:
- McuAxiClock  in  1  clock.
- mMcuAxiReset_n  in  1  sync active-low reset.
- mDebugMcu_AXI_awaddr  in  32  write address.
- mDebugMcu_AXI_awprot  in  3  ignored.
- mDebugMcu_AXI_awvalid  in  1  write address valid.
- mDebugMcu_AXI_awready  out  1  write address ready.
- mDebugMcu_AXI_wdata  in  32  write data.
- mDebugMcu_AXI_wstrb  in  4  byte enables.
- mDebugMcu_AXI_wvalid  in  1  write data valid.
- mDebugMcu_AXI_wready  out  1  write data ready.
- mDebugMcu_AXI_bresp  out  2  write response.
- mDebugMcu_AXI_bvalid  out  1  write response valid.
- mDebugMcu_AXI_bready  in  1  write response ready.
- mDebugMcu_AXI_araddr  in  32  read address.
- mDebugMcu_AXI_arprot  in  3  ignored.
- mDebugMcu_AXI_arvalid  in  1  read address valid.
- mDebugMcu_AXI_arready  out  1  read address ready.
- mDebugMcu_AXI_rdata  out  32  read data.
- mDebugMcu_AXI_rresp  out  2  read response.
- mDebugMcu_AXI_rvalid  out  1  read data valid.
- mDebugMcu_AXI_rready  in  1  read data ready.
- mDebugControl  out  32  CONTROL register contents.
- mDebugControlWr  out  1  one-cycle pulse on any accepted CONTROL write.
- mDebugStatus  in  32  status, same clock domain.

Function
REQ-005 The register map (offset = addr[7:0], addr[1:0] ignored) SHALL be: 0x00 ID (RO), 0x04 CONTROL (RW), 0x08 STATUS (RO, live mDebugStatus), 0x0C SCRATCH (RW), 0x10/0x14/0x18/0x1C MBOX0-3 (RW).
REQ-006 An address SHALL decode as a hit only when addr[31:8]==ADDR_BASE[31:8] and the offset is mapped; every other address is a miss.
REQ-007 The write FSM SHALL have states W_IDLE and W_RESP; in W_IDLE, awready=1 until AW is latched and wready=1 until W is latched; AW and W MAY arrive in either order or in the same cycle.
REQ-008 On the edge where both AW and W are held, the write SHALL commit per byte lane of wstrb, and the FSM SHALL enter W_RESP with bvalid=1.
REQ-009 bresp SHALL be OKAY (2'b00) for RW hits, OKAY with no effect for RO hits, and SLVERR (2'b10) for misses, which have no effect.
REQ-010 In W_RESP, awready=wready=0 and bvalid SHALL hold with stable bresp until bready=1, then return to W_IDLE.
REQ-011 mDebugControlWr SHALL pulse for exactly one cycle, on the cycle after a CONTROL commit, even when wstrb=4'b0000.
REQ-012 The read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE.
REQ-013 On an AR handshake, rdata and rresp SHALL be registered from current contents, giving rvalid=1 on the next cycle (one-cycle latency).
REQ-014 Reads that miss SHALL return rdata=0 with rresp=SLVERR.
REQ-015 rvalid, rdata and rresp SHALL hold until rready=1, then return to R_IDLE; back-to-back reads SHALL have at most one idle arready cycle.
REQ-016 Read and write FSMs SHALL be independent; a read and a write to the same register on the same edge SHALL return the pre-write value.

Reset
REQ-017 While mMcuAxiReset_n=0 at an edge: both FSMs SHALL go idle; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; CONTROL, SCRATCH and MBOX0-3 SHALL be 0; mDebugControlWr=0; any latched AW/W SHALL be discarded.
REQ-018 awready, wready and arready SHALL assert on the first cycle after reset deasserts; reset mid-transaction SHALL abort it without a response.

Configuration
REQ-019 When DFX_DEBUG_TIMESTAMP_EN is defined, the block SHALL add a 64-bit free-running counter (reset 0, +1 per cycle, wrapping at 2^64-1 to 0), mapped at 0x20 TS_LO and 0x24 TS_HI (RO).
REQ-020 A TS_LO read SHALL snapshot the upper 32 bits, and a TS_HI read SHALL return that snapshot.
REQ-021 When DFX_DEBUG_TIMESTAMP_EN is not defined, the counter SHALL be absent and 0x20/0x24 SHALL be misses.

Verification
REQ-022 Write 0x04 data 0xA5A5_1234 wstrb 0xF with AW 3 cycles before W -> bresp OKAY, mDebugControl=0xA5A5_1234, mDebugControlWr pulses once.
REQ-023 Write 0x0C data 0xFFFF_FFFF wstrb 0x5 after SCRATCH=0 -> read 0x0C returns 0x00FF_00FF, OKAY, rvalid one cycle after the AR handshake.
REQ-024 Read 0x00; write 0x00; read 0x40; write ADDR_BASE+0x100 -> ID_VALUE/OKAY; OKAY with ID unchanged; 0/SLVERR; SLVERR.
REQ-025 Hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid and payloads stable, arready=awready=0 throughout.
REQ-026 Assert reset while in W_RESP with MBOX2=0x1 -> bvalid=0 and MBOX2=0 the next cycle, readies high the cycle after release.
REQ-027 With the macro defined, preload the counter to 0x0000_0000_FFFF_FFFF and read TS_LO then TS_HI -> consistent snapshot (0xFFFF_FFFF, 0x0); without the macro, read 0x20 -> SLVERR.

Source files
------------

// File: rtl/dfx_debug_reg_responder.sv
// dfx_debug_reg_responder
// AXI4-Lite slave that exposes a small debug register window:
//   0x00 ID (RO), 0x04 CONTROL (RW), 0x08 STATUS (RO, live input),
//   0x0C SCRATCH (RW), 0x10..0x1C MBOX0-3 (RW).
// Optional feature macro: DFX_DEBUG_TIMESTAMP_EN adds a 64-bit free-running
// timestamp at 0x20 TS_LO / 0x24 TS_HI (RO). Reading TS_LO captures the upper
// word so a following TS_HI read returns a coherent 64-bit value.
// Without the macro, 0x20/0x24 decode as misses.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where valid and ready are both 1; a source holds valid and payload stable
// until that edge, and a sink may raise ready regardless of valid.
//
// Write FSM (w_state): W_IDLE accepts AW and W independently (either order or
// together) and commits on the edge where both are held; W_RESP holds bvalid
// until bready. Read FSM (r_state): R_IDLE accepts AR and registers the data,
// R_DATA holds rvalid until rready. The two FSMs are independent.
module dfx_debug_reg_responder #(
    parameter logic [31:0] ID_VALUE  = 32'hDF0C_0001,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        McuAxiClock,
    input  logic        mMcuAxiReset_n,
    input  logic [31:0] mDebugMcu_AXI_awaddr,
    input  logic [2:0]  mDebugMcu_AXI_awprot,
    input  logic        mDebugMcu_AXI_awvalid,
    output logic        mDebugMcu_AXI_awready,
    input  logic [31:0] mDebugMcu_AXI_wdata,
    input  logic [3:0]  mDebugMcu_AXI_wstrb,
    input  logic        mDebugMcu_AXI_wvalid,
    output logic        mDebugMcu_AXI_wready,
    output logic [1:0]  mDebugMcu_AXI_bresp,
    output logic        mDebugMcu_AXI_bvalid,
    input  logic        mDebugMcu_AXI_bready,
    input  logic [31:0] mDebugMcu_AXI_araddr,
    input  logic [2:0]  mDebugMcu_AXI_arprot,
    input  logic        mDebugMcu_AXI_arvalid,
    output logic        mDebugMcu_AXI_arready,
    output logic [31:0] mDebugMcu_AXI_rdata,
    output logic [1:0]  mDebugMcu_AXI_rresp,
    output logic        mDebugMcu_AXI_rvalid,
    input  logic        mDebugMcu_AXI_rready,
    output logic [31:0] mDebugControl,
    output logic        mDebugControlWr,
    input  logic [31:0] mDebugStatus
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word indices within the 256-byte window (byte offset >> 2).
    localparam logic [5:0] IDX_ID      = 6'd0;
    localparam logic [5:0] IDX_CONTROL = 6'd1;
    localparam logic [5:0] IDX_STATUS  = 6'd2;
    localparam logic [5:0] IDX_SCRATCH = 6'd3;
    localparam logic [5:0] IDX_MBOX0   = 6'd4;
    localparam logic [5:0] IDX_MBOX1   = 6'd5;
    localparam logic [5:0] IDX_MBOX2   = 6'd6;
    localparam logic [5:0] IDX_MBOX3   = 6'd7;
`ifdef DFX_DEBUG_TIMESTAMP_EN
    localparam logic [5:0] IDX_TS_LO   = 6'd8;
    localparam logic [5:0] IDX_TS_HI   = 6'd9;
`endif

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // FSM state, visible by name for checkers bound to this module.
    w_state_t w_state;
    r_state_t r_state;

    // Register file.
    logic [31:0] control;
    logic [31:0] scratch;
    logic [31:0] mbox0;
    logic [31:0] mbox1;
    logic [31:0] mbox2;
    logic [31:0] mbox3;

    // Write channel state: AW and W may be captured on different cycles.
    logic        aw_held;
    logic        w_held;
    logic [29:0] awaddr_q;     // word address, byte bits dropped
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_rdy;
    logic        w_rdy;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ctrl_wr;

    // Read channel registered outputs.
    logic        ar_rdy;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

`ifdef DFX_DEBUG_TIMESTAMP_EN
    logic [63:0] ts_count;
    logic [31:0] ts_hi_snap;
`endif

    // Byte-lane merge of new data into an existing register value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    // True when the word address lies in this block's 256-byte page.
    function automatic logic page_hit(input logic [29:0] waddr);
        return waddr[29:6] == ADDR_BASE[31:8];
    endfunction

    // True for any mapped register (RO or RW).
    function automatic logic idx_mapped(input logic [5:0] idx);
        logic m;
        m = (idx <= IDX_MBOX3);
`ifdef DFX_DEBUG_TIMESTAMP_EN
        m = m || (idx == IDX_TS_LO) || (idx == IDX_TS_HI);
`endif
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------
    logic        aw_fire;
    logic        w_fire;
    logic        have_aw;
    logic        have_w;
    logic [29:0] wr_waddr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [5:0]  wr_idx;
    logic        wr_hit;
    logic        wr_commit;

    assign aw_fire   = mDebugMcu_AXI_awvalid && aw_rdy;
    assign w_fire    = mDebugMcu_AXI_wvalid  && w_rdy;
    assign have_aw   = aw_held || aw_fire;
    assign have_w    = w_held  || w_fire;
    assign wr_waddr  = aw_held ? awaddr_q : mDebugMcu_AXI_awaddr[31:2];
    assign wr_data   = w_held  ? wdata_q  : mDebugMcu_AXI_wdata;
    assign wr_strb   = w_held  ? wstrb_q  : mDebugMcu_AXI_wstrb;
    assign wr_idx    = wr_waddr[5:0];
    assign wr_hit    = page_hit(wr_waddr) && idx_mapped(wr_idx);
    assign wr_commit = (w_state == W_IDLE) && have_aw && have_w;

    // Write FSM, AW/W capture, register file updates and CONTROL pulse.
    always_ff @(posedge McuAxiClock) begin
        if (!mMcuAxiReset_n) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_rdy   <= 1'b0;
            w_rdy    <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            ctrl_wr  <= 1'b0;
            control  <= '0;
            scratch  <= '0;
            mbox0    <= '0;
            mbox1    <= '0;
            mbox2    <= '0;
            mbox3    <= '0;
        end else begin
            ctrl_wr <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (wr_commit) begin
                        // Only RW registers change; RO hits and misses are no-ops.
                        if (wr_hit) begin
                            case (wr_idx)
                                IDX_CONTROL: begin
                                    control <= lane_merge(control, wr_data, wr_strb);
                                    ctrl_wr <= 1'b1;
                                end
                                IDX_SCRATCH: scratch <= lane_merge(scratch, wr_data, wr_strb);
                                IDX_MBOX0:   mbox0   <= lane_merge(mbox0,   wr_data, wr_strb);
                                IDX_MBOX1:   mbox1   <= lane_merge(mbox1,   wr_data, wr_strb);
                                IDX_MBOX2:   mbox2   <= lane_merge(mbox2,   wr_data, wr_strb);
                                IDX_MBOX3:   mbox3   <= lane_merge(mbox3,   wr_data, wr_strb);
                                default: ;
                            endcase
                        end
                        b_resp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                        b_valid <= 1'b1;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        aw_rdy  <= 1'b0;
                        w_rdy   <= 1'b0;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held  <= 1'b1;
                            awaddr_q <= mDebugMcu_AXI_awaddr[31:2];
                        end
                        if (w_fire) begin
                            w_held  <= 1'b1;
                            wdata_q <= mDebugMcu_AXI_wdata;
                            wstrb_q <= mDebugMcu_AXI_wstrb;
                        end
                        // Each channel stays ready until its beat is captured.
                        aw_rdy <= !have_aw;
                        w_rdy  <= !have_w;
                    end
                end
                W_RESP: begin
                    if (mDebugMcu_AXI_bready) begin
                        b_valid <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_rdy   <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-side decode: values are taken from current register contents,
    // so a write committing on the same edge is not yet visible.
    // ------------------------------------------------------------------
    logic [29:0] rd_waddr;
    logic [5:0]  rd_idx;
    logic        rd_hit;
    logic [31:0] rd_word;
    logic        ar_fire;

    assign rd_waddr = mDebugMcu_AXI_araddr[31:2];
    assign rd_idx   = rd_waddr[5:0];
    assign ar_fire  = mDebugMcu_AXI_arvalid && ar_rdy;

    // Read data multiplexer.
    always_comb begin
        rd_hit  = page_hit(rd_waddr) && idx_mapped(rd_idx);
        rd_word = '0;
        case (rd_idx)
            IDX_ID:      rd_word = ID_VALUE;
            IDX_CONTROL: rd_word = control;
            IDX_STATUS:  rd_word = mDebugStatus;
            IDX_SCRATCH: rd_word = scratch;
            IDX_MBOX0:   rd_word = mbox0;
            IDX_MBOX1:   rd_word = mbox1;
            IDX_MBOX2:   rd_word = mbox2;
            IDX_MBOX3:   rd_word = mbox3;
`ifdef DFX_DEBUG_TIMESTAMP_EN
            IDX_TS_LO:   rd_word = ts_count[31:0];
            IDX_TS_HI:   rd_word = ts_hi_snap;
`endif
            default:     rd_word = '0;
        endcase
        if (!rd_hit) begin
            rd_word = '0;
        end
    end

    // Read FSM with one-cycle registered data path.
    always_ff @(posedge McuAxiClock) begin
        if (!mMcuAxiReset_n) begin
            r_state <= R_IDLE;
            ar_rdy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
`ifdef DFX_DEBUG_TIMESTAMP_EN
            ts_hi_snap <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_rdy <= 1'b1;
                    if (ar_fire) begin
                        r_data  <= rd_word;
                        r_resp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                        r_valid <= 1'b1;
                        ar_rdy  <= 1'b0;
                        r_state <= R_DATA;
`ifdef DFX_DEBUG_TIMESTAMP_EN
                        // Freeze the upper word alongside the lower-word read.
                        if (rd_hit && rd_idx == IDX_TS_LO) begin
                            ts_hi_snap <= ts_count[63:32];
                        end
`endif
                    end
                end
                R_DATA: begin
                    if (mDebugMcu_AXI_rready) begin
                        r_valid <= 1'b0;
                        ar_rdy  <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef DFX_DEBUG_TIMESTAMP_EN
    // Free-running 64-bit timestamp; wraps naturally at 2^64-1.
    always_ff @(posedge McuAxiClock) begin
        if (!mMcuAxiReset_n) begin
            ts_count <= '0;
        end else begin
            ts_count <= ts_count + 64'd1;
        end
    end
`endif

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{mDebugMcu_AXI_awprot, mDebugMcu_AXI_arprot,
                             mDebugMcu_AXI_awaddr[1:0], mDebugMcu_AXI_araddr[1:0]};

    assign mDebugMcu_AXI_awready = aw_rdy;
    assign mDebugMcu_AXI_wready  = w_rdy;
    assign mDebugMcu_AXI_bvalid  = b_valid;
    assign mDebugMcu_AXI_bresp   = b_resp;
    assign mDebugMcu_AXI_arready = ar_rdy;
    assign mDebugMcu_AXI_rvalid  = r_valid;
    assign mDebugMcu_AXI_rdata   = r_data;
    assign mDebugMcu_AXI_rresp   = r_resp;
    assign mDebugControl         = control;
    assign mDebugControlWr       = ctrl_wr;

endmodule
